// File: rtl/board_mem_pkg.sv
// board_mem_pkg -- shared types for the board memory arbiter slice.
//   clr_state_e       : clear-sequencer FSM states (IDLE, CLEAR, DONE)
//   cell_e            : encoding of one board cell (EMPTY, BLACK, WHITE)
//   CLR_VALUE_DEFAULT : value the clear sweep writes unless overridden
package board_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BLACK = 2'd1,
        WHITE = 2'd2
    } cell_e;

    localparam cell_e CLR_VALUE_DEFAULT = EMPTY;

endpackage

// File: rtl/board_mem_arbiter_if.sv
// board_mem_arbiter_if -- requester-side bundle of the board memory arbiter.
//   Port A  : a_req, a_addr -> a_gnt, a_rvalid, a_rdata   (display, read-only)
//   Port B  : b_req, b_we, b_addr, b_wdata -> b_gnt, b_rvalid, b_rdata
//   Clear   : clr_start -> clr_busy, clr_done
//   master  : the requesters (display, game logic, clear command source)
//   slave   : the arbiter
interface board_mem_arbiter_if #(
    parameter int BITS  = 2,
    parameter int ABITS = 8
);
    logic             a_req;
    logic [ABITS-1:0] a_addr;
    logic             a_gnt;
    logic             a_rvalid;
    logic [BITS-1:0]  a_rdata;

    logic             b_req;
    logic             b_we;
    logic [ABITS-1:0] b_addr;
    logic [BITS-1:0]  b_wdata;
    logic             b_gnt;
    logic             b_rvalid;
    logic [BITS-1:0]  b_rdata;

    logic             clr_start;
    logic             clr_busy;
    logic             clr_done;

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, clr_start,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
               clr_busy, clr_done
    );

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, clr_start,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
               clr_busy, clr_done
    );
endinterface

// File: rtl/board_rr_arbiter.sv
// board_rr_arbiter -- two-way round-robin arbiter with combinational grant.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request vector (bit 0 = port A, bit 1 = port B)
//   gnt[1:0] : one-hot grant; a grant is an accept, the pointer then
//              moves to favour the other port
module board_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prefer_b;

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prefer_b)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_b <= 1'b0;
        end else if (|gnt) begin
            prefer_b <= gnt[0];
        end
    end
endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter -- shares one single-port board memory between the
// display (port A, read-only) and game logic (port B, read/write), plus an
// optional clear sequencer that sweeps CLR_VALUE over every cell.
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : port A / port B handshakes and clear command
//   mem_wen, mem_ren : memory write / read strobe (never both high)
//   mem_addr, mem_din: memory address / write data, driven in grant cycle
//   mem_dout         : memory read data, valid one cycle after mem_ren
// Build option: define BOARD_MEM_ARBITER_CLR_EN to include the clear
// sequencer; without it clr_start is ignored and clr_busy/clr_done are 0.
module board_mem_arbiter
    import board_mem_pkg::*;
#(
    parameter int              BITS      = 2,
    parameter int              WORDS     = 256,
    parameter logic [BITS-1:0] CLR_VALUE = BITS'(CLR_VALUE_DEFAULT),
    localparam int             ABITS     = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    board_mem_arbiter_if.slave  bus,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [ABITS-1:0]    mem_addr,
    output logic [BITS-1:0]     mem_din,
    input  logic [BITS-1:0]     mem_dout
);
    logic             allow;       // arbitration open this cycle
    logic             clearing;    // sweep owns the memory this cycle
    logic [ABITS-1:0] sweep_addr;
    logic [1:0]       gnt;
    logic             a_rvalid_q;
    logic             b_rvalid_q;

`ifdef BOARD_MEM_ARBITER_CLR_EN
    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(WORDS - 1);

    clr_state_e       state;
    logic [ABITS-1:0] cnt;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        state  <= ST_CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Stop on the last real address so a non-power-of-two
                    // WORDS never runs the counter past the array.
                    if (cnt == LAST_ADDR) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + ABITS'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // A clr_start seen in IDLE beats any pending request that cycle.
    assign allow        = (state == ST_IDLE) && !bus.clr_start;
    assign clearing     = (state == ST_CLEAR);
    assign sweep_addr   = cnt;
    assign bus.clr_busy = busy_q;
    assign bus.clr_done = done_q;
`else
    logic unused_clr_start;

    assign unused_clr_start = bus.clr_start;
    assign allow            = 1'b1;
    assign clearing         = 1'b0;
    assign sweep_addr       = '0;
    assign bus.clr_busy     = 1'b0;
    assign bus.clr_done     = 1'b0;
`endif

    board_rr_arbiter u_rr (
        .clk (clk),
        .rst (rst),
        .req ({bus.b_req, bus.a_req} & {2{allow && !rst}}),
        .gnt (gnt)
    );

    assign bus.a_gnt = gnt[0];
    assign bus.b_gnt = gnt[1];

    always_comb begin
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        mem_addr = bus.a_addr;
        mem_din  = CLR_VALUE;
        if (clearing && !rst) begin
            mem_wen  = 1'b1;
            mem_addr = sweep_addr;
        end else if (gnt[0]) begin
            mem_ren  = 1'b1;
            mem_addr = bus.a_addr;
        end else if (gnt[1]) begin
            mem_wen  = bus.b_we;
            mem_ren  = !bus.b_we;
            mem_addr = bus.b_addr;
            mem_din  = bus.b_wdata;
        end
    end

    // rvalid tracks the read issued last cycle; it is independent of the
    // sweep, so a read granted just before a clear still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= gnt[0];
            b_rvalid_q <= gnt[1] && !bus.b_we;
        end
    end

    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = mem_dout;
    assign bus.b_rdata  = mem_dout;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter -- directed bench for board_mem_arbiter with a
// 256 x 2-bit single-port memory model (1-cycle read latency, read data
// holds during writes). Clear-sequencer checks follow whichever build
// BOARD_MEM_ARBITER_CLR_EN selects.
module tb_board_mem_arbiter;

    localparam int BITS  = 2;
    localparam int WORDS = 256;
    localparam int ABITS = 8;

    logic             clk;
    logic             rst;
    logic             mem_wen;
    logic             mem_ren;
    logic [ABITS-1:0] mem_addr;
    logic [BITS-1:0]  mem_din;
    logic [BITS-1:0]  mem_dout;

    board_mem_arbiter_if #(.BITS(BITS), .ABITS(ABITS)) bus ();

    board_mem_arbiter #(.BITS(BITS), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .mem_wen  (mem_wen),
        .mem_ren  (mem_ren),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; load_mode preloads a pattern (1: i%3 with cell 7 = 2,
    // 2: every cell = 1).
    logic [BITS-1:0] mem [WORDS];
    int              load_mode;
    int              wr_count;

    initial wr_count = 0;

    always @(posedge clk) begin
        if (load_mode == 1) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= BITS'(i % 3);
            mem[7] <= 2'd2;
        end else if (load_mode == 2) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 2'd1;
        end else if (mem_wen) begin
            mem[mem_addr] <= mem_din;
            wr_count      <= wr_count + 1;
        end else if (mem_ren) begin
            mem_dout <= mem[mem_addr];
        end
    end

    int n_chk;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             a_req;
        logic [ABITS-1:0] a_addr;
        logic             b_req;
        logic             b_we;
        logic [ABITS-1:0] b_addr;
        logic [BITS-1:0]  b_wdata;
        logic             e_ag;
        logic             e_bg;
        logic             e_wen;
        logic             e_ren;
        logic [ABITS-1:0] e_addr;
        logic             e_arv;
        logic             e_brv;
        logic [BITS-1:0]  e_rdata;
    } vec_t;

    vec_t vecs [15];

    initial begin
        n_chk = 0;
        n_err = 0;

        // a_req a_addr b_req b_we b_addr b_wdata | ag bg wen ren addr | arv brv rdata
        vecs[0]  = '{1, 5,  0, 0, 0, 0,  1, 0, 0, 1, 5,   1, 0, 2}; // lone A read
        vecs[1]  = '{0, 0,  1, 1, 7, 1,  0, 1, 1, 0, 7,   0, 0, 0}; // B write 7<=1
        vecs[2]  = '{0, 0,  1, 0, 7, 0,  0, 1, 0, 1, 7,   0, 1, 1}; // B read 7
        vecs[3]  = '{1, 11, 1, 0, 4, 0,  1, 0, 0, 1, 11,  1, 0, 2}; // both: A
        vecs[4]  = '{1, 3,  1, 0, 4, 0,  0, 1, 0, 1, 4,   0, 1, 1}; // both: B
        vecs[5]  = '{1, 3,  1, 1, 8, 1,  1, 0, 0, 1, 3,   1, 0, 0}; // both: A
        vecs[6]  = '{1, 10, 1, 1, 8, 1,  0, 1, 1, 0, 8,   0, 0, 0}; // both: B write
        vecs[7]  = '{1, 10, 1, 0, 8, 0,  1, 0, 0, 1, 10,  1, 0, 1}; // both: A
        vecs[8]  = '{1, 0,  1, 0, 8, 0,  0, 1, 0, 1, 8,   0, 1, 1}; // both: B
        vecs[9]  = '{0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0}; // idle
        vecs[10] = '{1, 5,  0, 0, 0, 0,  1, 0, 0, 1, 5,   1, 0, 2}; // A
        vecs[11] = '{1, 6,  0, 0, 0, 0,  1, 0, 0, 1, 6,   1, 0, 0}; // A back-to-back
        vecs[12] = '{0, 0,  1, 1, 6, 2,  0, 1, 1, 0, 6,   0, 0, 0}; // B write 6<=2
        vecs[13] = '{1, 6,  1, 0, 9, 0,  1, 0, 0, 1, 6,   1, 0, 2}; // both: A
        vecs[14] = '{0, 0,  1, 0, 11, 0, 0, 1, 0, 1, 11,  0, 1, 2}; // lone B read

        // Reset with both requests asserted: nothing may be granted.
        rst           = 1'b1;
        load_mode     = 1;
        bus.a_req     = 1'b1;
        bus.a_addr    = '0;
        bus.b_req     = 1'b1;
        bus.b_we      = 1'b0;
        bus.b_addr    = '0;
        bus.b_wdata   = '0;
        bus.clr_start = 1'b0;
        tick();
        load_mode = 0;
        tick();
        check("rst_a_gnt",    32'(bus.a_gnt),    0);
        check("rst_b_gnt",    32'(bus.b_gnt),    0);
        check("rst_a_rvalid", 32'(bus.a_rvalid), 0);
        check("rst_b_rvalid", 32'(bus.b_rvalid), 0);
        check("rst_clr_busy", 32'(bus.clr_busy), 0);
        check("rst_clr_done", 32'(bus.clr_done), 0);
        check("rst_mem_wen",  32'(mem_wen),      0);
        check("rst_mem_ren",  32'(mem_ren),      0);
        rst       = 1'b0;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;

        for (int v = 0; v < 15; v++) begin
            bus.a_req   = vecs[v].a_req;
            bus.a_addr  = vecs[v].a_addr;
            bus.b_req   = vecs[v].b_req;
            bus.b_we    = vecs[v].b_we;
            bus.b_addr  = vecs[v].b_addr;
            bus.b_wdata = vecs[v].b_wdata;
            #1;
            check($sformatf("v%0d_a_gnt", v),   32'(bus.a_gnt), 32'(vecs[v].e_ag));
            check($sformatf("v%0d_b_gnt", v),   32'(bus.b_gnt), 32'(vecs[v].e_bg));
            check($sformatf("v%0d_mem_wen", v), 32'(mem_wen),   32'(vecs[v].e_wen));
            check($sformatf("v%0d_mem_ren", v), 32'(mem_ren),   32'(vecs[v].e_ren));
            if (vecs[v].e_wen || vecs[v].e_ren)
                check($sformatf("v%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].e_addr));
            if (vecs[v].e_wen)
                check($sformatf("v%0d_mem_din", v), 32'(mem_din), 32'(vecs[v].b_wdata));
            tick();
            check($sformatf("v%0d_a_rvalid", v), 32'(bus.a_rvalid), 32'(vecs[v].e_arv));
            check($sformatf("v%0d_b_rvalid", v), 32'(bus.b_rvalid), 32'(vecs[v].e_brv));
            if (vecs[v].e_arv)
                check($sformatf("v%0d_a_rdata", v), 32'(bus.a_rdata), 32'(vecs[v].e_rdata));
            if (vecs[v].e_brv)
                check($sformatf("v%0d_b_rdata", v), 32'(bus.b_rdata), 32'(vecs[v].e_rdata));
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;

`ifdef BOARD_MEM_ARBITER_CLR_EN
        begin
            int busy_n;
            int bad;
            int gnt_seen;
            int nz;

            // Read cell 7 (holds 1), then clr_start next to a pending A.
            bus.a_req  = 1'b1;
            bus.a_addr = 8'd7;
            #1;
            check("pre_clr_a_gnt", 32'(bus.a_gnt), 1);
            tick();
            bus.a_addr    = 8'd5;
            bus.clr_start = 1'b1;
            #1;
            check("clr_prio_a_gnt", 32'(bus.a_gnt), 0);
            check("clr_prio_mem",   32'(mem_wen | mem_ren), 0);
            check("owed_a_rvalid",  32'(bus.a_rvalid), 1);
            check("owed_a_rdata",   32'(bus.a_rdata), 1);
            tick();
            bus.clr_start = 1'b0;

            // Sweep: one ascending write per cycle, no grants, and a
            // second clr_start mid-sweep must not restart it.
            busy_n   = 0;
            bad      = 0;
            gnt_seen = 0;
            for (int i = 0; i < 300 && bus.clr_busy; i++) begin
                if (!mem_wen || mem_ren || int'(mem_addr) != i || mem_din != 2'd0) bad++;
                if (bus.a_gnt || bus.b_gnt) gnt_seen++;
                busy_n++;
                bus.clr_start = (i == 50);
                tick();
            end
            bus.clr_start = 1'b0;
            check("sweep_busy_cycles", 32'(busy_n),   256);
            check("sweep_write_seq",   32'(bad),      0);
            check("sweep_no_grant",    32'(gnt_seen), 0);
            check("done_pulse",        32'(bus.clr_done), 1);
            check("done_busy_low",     32'(bus.clr_busy), 0);
            check("done_no_grant",     32'(bus.a_gnt),    0);
            tick();
            check("idle_done_low",     32'(bus.clr_done), 0);
            check("idle_pending_gnt",  32'(bus.a_gnt),    1);
            tick();
            check("post_clr_a_rvalid", 32'(bus.a_rvalid), 1);
            check("post_clr_a_rdata",  32'(bus.a_rdata),  0);

            // Read the whole board back through port A.
            nz = 0;
            for (int i = 0; i < WORDS; i++) begin
                bus.a_addr = ABITS'(i);
                tick();
                if (!bus.a_rvalid || bus.a_rdata != 2'd0) nz++;
            end
            bus.a_req = 1'b0;
            check("readback_all_zero", 32'(nz), 0);
            tick();

            // Abort: reset lands while the sweep is at address 100.
            load_mode = 2;
            tick();
            load_mode     = 0;
            bus.clr_start = 1'b1;
            tick();
            bus.clr_start = 1'b0;
            repeat (100) tick();
            check("abort_addr", 32'(mem_addr), 100);
            rst = 1'b1;
            #1;
            check("abort_rst_wen", 32'(mem_wen), 0);
            tick();
            rst = 1'b0;
            check("abort_busy_low", 32'(bus.clr_busy), 0);
            gnt_seen = 0;
            for (int i = 0; i < 5; i++) begin
                if (bus.clr_done || bus.clr_busy) gnt_seen++;
                tick();
            end
            check("abort_no_done", 32'(gnt_seen), 0);
            bad = 0;
            for (int i = 0; i < WORDS; i++) begin
                if (i < 100 && mem[i] != 2'd0) bad++;
                if (i >= 100 && mem[i] != 2'd1) bad++;
            end
            check("abort_partial_clear", 32'(bad), 0);
        end
`else
        begin
            int base;
            int flag_seen;

            // clr_start is ignored: a pending request is still granted.
            base          = wr_count;
            flag_seen     = 0;
            bus.a_req     = 1'b1;
            bus.a_addr    = 8'd5;
            bus.clr_start = 1'b1;
            #1;
            check("noclr_a_gnt", 32'(bus.a_gnt), 1);
            tick();
            bus.a_req = 1'b0;
            for (int i = 0; i < 40; i++) begin
                bus.clr_start = (i % 7 == 0);
                if (bus.clr_busy || bus.clr_done || mem_wen) flag_seen++;
                tick();
            end
            bus.clr_start = 1'b0;
            check("noclr_flags",  32'(flag_seen),       0);
            check("noclr_writes", 32'(wr_count - base), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
- REQ-001: Parameter BITS, default 2, bits per board cell.
- REQ-002: Parameter WORDS, default 256, number of board cells; ABITS = $clog2(WORDS).
- REQ-003: Parameter CLR_VALUE, default 0 (BITS wide), value written by clear sweep.
- REQ-004: clk  in  1  sole clock, all logic on posedge.
- REQ-005: rst  in  1  synchronous, active-high reset.
- REQ-006: a_req in 1 / a_addr in ABITS: display read request (read-only port A).
- REQ-007: a_gnt out 1 / a_rvalid out 1 / a_rdata out BITS: port A grant, read-data valid, read data.
- REQ-008: b_req in 1 / b_we in 1 / b_addr in ABITS / b_wdata in BITS: game-logic request (port B).
- REQ-009: b_gnt out 1 / b_rvalid out 1 / b_rdata out BITS: port B grant, read-data valid, read data.
- REQ-010: clr_start in 1 / clr_busy out 1 / clr_done out 1: board-clear command, sweep active, one-cycle completion pulse.
- REQ-011: mem_wen out 1 / mem_ren out 1 / mem_addr out ABITS / mem_din out BITS / mem_dout in BITS: single-port memory side; memory read latency 1 cycle; mem_dout holds during writes.

Function
- REQ-012: At most one of mem_wen/mem_ren SHALL be high per cycle; mem_addr/mem_din SHALL be driven by the granted source, combinationally, in the grant cycle.
- REQ-013: gnt SHALL be combinational; a request is accepted in a cycle where req && gnt; requesters hold req/addr/data stable until gnt.
- REQ-014: Both requesting in IDLE: round-robin, the port not granted most recently wins; pointer resets to favour A.
- REQ-015: Single requester in IDLE SHALL be granted the same cycle; back-to-back grants to one port allowed every cycle.
- REQ-016: Granted read SHALL raise that port's rvalid exactly 1 cycle later with rdata = mem_dout; rdata is don't-care while rvalid low.
- REQ-017: Granted port-B write (b_we=1) SHALL assert mem_wen only; no b_rvalid follows.
- REQ-018: FSM states IDLE, CLEAR, DONE. IDLE->CLEAR on clr_start; CLEAR->DONE after writing address WORDS-1; DONE->IDLE unconditionally.
- REQ-019: CLEAR SHALL write CLR_VALUE to addresses 0..WORDS-1 ascending, one per cycle, WORDS cycles total; clr_busy high throughout CLEAR.
- REQ-020: clr_done SHALL pulse high for exactly the one cycle in DONE.
- REQ-021: In CLEAR and DONE, a_gnt and b_gnt SHALL be 0; requests stay pending.
- REQ-022: clr_start while clr_busy SHALL be ignored; clr_start in the same cycle as pending requests takes priority (no grant that cycle, CLEAR next cycle).
- REQ-023: An rvalid owed from a read granted in the cycle clr_start is sampled SHALL still be delivered.
- REQ-024: Address counter SHALL not wrap past WORDS-1; WORDS non-power-of-two supported.

Reset
- REQ-025: On rst: state IDLE, counter 0, RR pointer favours A, all gnt/rvalid/clr_busy/clr_done/mem_wen/mem_ren 0.
- REQ-026: rst during CLEAR SHALL abort the sweep with no clr_done; memory contents left partially cleared.

Configuration
- REQ-027: Macro BOARD_MEM_ARBITER_CLR_EN defined: clear sequencer per REQ-018..REQ-024 present.
- REQ-028: Macro undefined: no FSM/counter; clr_start ignored, clr_busy and clr_done tied 0; ports unchanged.

Structure
- REQ-029: Package board_mem_pkg SHALL hold the FSM state enum, cell typedef (EMPTY=0, BLACK=1, WHITE=2) and default CLR_VALUE.
- REQ-030: Two-way round-robin logic SHALL be a sub-module board_rr_arbiter (req[1:0] -> gnt[1:0], update on accept).

Verification
- REQ-031: Memory preloaded addr 5=2; a_req addr 5 alone -> a_gnt same cycle, a_rvalid next cycle with a_rdata=2.
- REQ-032: b write addr 7 data 1, then b read addr 7 -> b_rdata=1 one cycle after second grant, no b_rvalid after the write.
- REQ-033: a_req and b_req held high 6 cycles -> grants alternate A,B,A,B,A,B.
- REQ-034: clr_start with WORDS=256 -> clr_busy 256 cycles, clr_done one pulse, all cells read back 0; a_req during sweep granted only after DONE.
- REQ-035: rst asserted at sweep address 100 -> addresses 0..99 cleared, 100..255 unchanged, no clr_done.
- REQ-036: Build without BOARD_MEM_ARBITER_CLR_EN, pulse clr_start -> no memory writes, clr_busy/clr_done stay 0.
